// File: rtl/adxl345_axis_reader.sv
// SPI mode-3 master that configures an ADXL345, then polls its data registers and publishes
// shifted, saturated 8-bit samples. Define ADXL_Y_AXIS_EN to also burst-read and publish Y.
module adxl345_axis_reader #(
   parameter int         CLK_DIV        = 25,
   parameter int         STARTUP_CYCLES = 100000,
   parameter int         POLL_CYCLES    = 50000,
   parameter int         CS_GAP         = 50,
   parameter logic [7:0] DATA_FORMAT    = 8'h00,
   parameter int         SHIFT          = 2
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   output logic       o_CS,
   output logic       o_SPC,
   output logic       o_SDI,
   input  logic       i_SDO,
   output logic [7:0] o_av_x,
   output logic [7:0] o_av_y,
   output logic       o_valid,
   output logic       o_ready
);
   localparam int DW = $clog2(CLK_DIV);
   localparam int SW = $clog2(STARTUP_CYCLES + 1);
   localparam int PW = $clog2(POLL_CYCLES + 1);
   localparam int GW = $clog2(CS_GAP + 1);
   localparam logic [DW-1:0] DIV_MAX   = DW'(CLK_DIV - 1);
   localparam logic [SW-1:0] START_MAX = SW'(STARTUP_CYCLES - 1);
   localparam logic [PW-1:0] POLL_MAX  = PW'(POLL_CYCLES - 1);
   localparam logic [GW-1:0] GAP_MAX   = GW'(CS_GAP - 1);
`ifdef ADXL_Y_AXIS_EN
   localparam int         RXW     = 32;
   localparam logic [5:0] RD_BITS = 6'd40;
`else
   localparam int         RXW     = 16;
   localparam logic [5:0] RD_BITS = 6'd24;
`endif

   typedef enum logic [2:0] {WAIT_START, CFG_FMT, CFG_PWR, POLL_WAIT, READ, UPDATE} state_t;
   typedef enum logic [1:0] {PH_FALL, PH_RISE, PH_END} phase_t;

   state_t           state_q;
   phase_t           ph_q;
   logic [SW-1:0]    start_q;
   logic [PW-1:0]    poll_q;
   logic [GW-1:0]    gap_q;
   logic [DW-1:0]    div_q;
   logic [5:0]       bits_q;
   logic [15:0]      tx_q;
   logic [RXW-1:0]   rx_q;
   logic             cs_q, spc_q, sdi_q, valid_q, ready_q;
   logic [7:0]       av_x_q;
`ifdef ADXL_Y_AXIS_EN
   logic [7:0]       av_y_q;
`endif

   logic end_evt, gap_ok, poll_ok;
   assign end_evt = !cs_q && (div_q == DIV_MAX) && (ph_q == PH_END);
   assign gap_ok  = cs_q && (gap_q == GAP_MAX);
   assign poll_ok = (poll_q == POLL_MAX);

   // Floor shift of the signed sample, then clamp into the signed byte range.
   function automatic logic [7:0] sat8(input logic [15:0] raw);
      logic signed [15:0] v;
      v = $signed(raw) >>> SHIFT;
      if (v > 16'sd127)       sat8 = 8'h7F;
      else if (v < -16'sd128) sat8 = 8'h80;
      else                    sat8 = v[7:0];
   endfunction

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= WAIT_START;
         ph_q    <= PH_FALL;
         start_q <= '0;
         poll_q  <= POLL_MAX;
         gap_q   <= GAP_MAX;
         div_q   <= '0;
         bits_q  <= '0;
         tx_q    <= '0;
         rx_q    <= '0;
         cs_q    <= 1'b1;
         spc_q   <= 1'b1;
         sdi_q   <= 1'b0;
         valid_q <= 1'b0;
         ready_q <= 1'b0;
         av_x_q  <= '0;
`ifdef ADXL_Y_AXIS_EN
         av_y_q  <= '0;
`endif
      end else begin
         valid_q <= 1'b0;
         if (cs_q && !gap_ok) gap_q <= gap_q + 1'b1;
         if (!poll_ok) poll_q <= poll_q + 1'b1;

         // Bit engine: every CLK_DIV cycles it takes the next step fall -> rise -> ... -> CS release.
         if (!cs_q) begin
            if (div_q == DIV_MAX) begin
               div_q <= '0;
               case (ph_q)
                  PH_FALL: begin
                     spc_q <= 1'b0;
                     sdi_q <= tx_q[15];
                     tx_q  <= {tx_q[14:0], 1'b0};
                     ph_q  <= PH_RISE;
                  end
                  PH_RISE: begin
                     spc_q  <= 1'b1;
                     rx_q   <= {rx_q[RXW-2:0], i_SDO};
                     bits_q <= bits_q - 1'b1;
                     ph_q   <= (bits_q == 6'd1) ? PH_END : PH_FALL;
                  end
                  default: begin
                     cs_q  <= 1'b1;
                     gap_q <= '0;
                  end
               endcase
            end else begin
               div_q <= div_q + 1'b1;
            end
         end

         case (state_q)
            WAIT_START: begin
               start_q <= start_q + 1'b1;
               if (start_q == START_MAX) begin
                  cs_q    <= 1'b0;
                  div_q   <= '0;
                  ph_q    <= PH_FALL;
                  tx_q    <= {8'h31, DATA_FORMAT};
                  bits_q  <= 6'd16;
                  state_q <= CFG_FMT;
               end
            end
            CFG_FMT: if (end_evt) state_q <= CFG_PWR;
            CFG_PWR: begin
               if (gap_ok) begin
                  cs_q   <= 1'b0;
                  div_q  <= '0;
                  ph_q   <= PH_FALL;
                  tx_q   <= 16'h2D08;
                  bits_q <= 6'd16;
               end
               if (end_evt) begin
                  ready_q <= 1'b1;
                  state_q <= POLL_WAIT;
               end
            end
            POLL_WAIT: begin
               if (gap_ok && poll_ok) begin
                  cs_q    <= 1'b0;
                  div_q   <= '0;
                  ph_q    <= PH_FALL;
                  tx_q    <= 16'hF200;
                  bits_q  <= RD_BITS;
                  poll_q  <= '0;
                  state_q <= READ;
               end
            end
            READ: if (end_evt) state_q <= UPDATE;
            UPDATE: begin
`ifdef ADXL_Y_AXIS_EN
               av_x_q <= sat8({rx_q[23:16], rx_q[31:24]});
               av_y_q <= sat8({rx_q[7:0], rx_q[15:8]});
`else
               av_x_q <= sat8({rx_q[7:0], rx_q[15:8]});
`endif
               valid_q <= 1'b1;
               state_q <= POLL_WAIT;
            end
            default: state_q <= WAIT_START;
         endcase
      end
   end

   assign o_CS    = cs_q;
   assign o_SPC   = spc_q;
   assign o_SDI   = sdi_q;
   assign o_av_x  = av_x_q;
`ifdef ADXL_Y_AXIS_EN
   assign o_av_y  = av_y_q;
`else
   assign o_av_y  = 8'h00;
`endif
   assign o_valid = valid_q;
   assign o_ready = ready_q;
endmodule

// File: tb/tb_adxl345_axis_reader.sv
// Bench for adxl345_axis_reader: SPI slave model, protocol monitor, reference arithmetic model
// and directed plus random reads, including a reset in the middle of a read.
module tb_adxl345_axis_reader;
   localparam int CLK_DIV = 2;
   localparam int STARTUP = 20;
   localparam int POLL    = 400;
   localparam int GAP     = 4;
   localparam int SHIFT   = 2;
`ifdef ADXL_Y_AXIS_EN
   localparam int RD_EDGES = 40;
   localparam int MID_EDGE = 28;
   localparam bit Y_EN     = 1'b1;
`else
   localparam int RD_EDGES = 24;
   localparam int MID_EDGE = 20;
   localparam bit Y_EN     = 1'b0;
`endif

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       i_sdo = 1'b0;
   logic       o_cs, o_spc, o_sdi, o_valid, o_ready;
   logic [7:0] o_av_x, o_av_y;

   adxl345_axis_reader #(
      .CLK_DIV(CLK_DIV), .STARTUP_CYCLES(STARTUP), .POLL_CYCLES(POLL),
      .CS_GAP(GAP), .DATA_FORMAT(8'h00), .SHIFT(SHIFT)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .o_CS(o_cs), .o_SPC(o_spc), .o_SDI(o_sdi),
      .i_SDO(i_sdo), .o_av_x(o_av_x), .o_av_y(o_av_y), .o_valid(o_valid), .o_ready(o_ready)
   );

   // ---------------- clock / counters ----------------
   int cyc = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   int n_cmp = 0, n_fail = 0, n_reads = 0, prev_start = -1;
   logic [15:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference arithmetic: floor-divide by 2**SHIFT, clamp to a signed byte.
   function automatic logic [7:0] model(input logic [15:0] raw);
      int r, d, q;
      r = int'($signed(raw));
      d = 1 << SHIFT;
      q = r / d;
      if (r < 0 && (r % d) != 0) q--;
      if (q > 127) q = 127;
      if (q < -128) q = -128;
      return 8'(q);
   endfunction

   // ---------------- SPI slave model ----------------
   logic [15:0] slave_x = '0, slave_y = '0;
   logic [39:0] s_miso = '0, s_mosi = '0;
   int          s_edges = 0;
   logic [39:0] tr_mosi[$];
   int          tr_edges[$];

   always @(negedge o_cs) begin
      s_edges = 0;
      s_mosi  = '0;
      s_miso  = {8'h00, slave_x[7:0], slave_x[15:8], slave_y[7:0], slave_y[15:8]};
   end
   always @(negedge o_spc) if (o_cs === 1'b0) begin
      i_sdo  = s_miso[39];
      s_miso = {s_miso[38:0], 1'b0};
   end
   always @(posedge o_spc) if (o_cs === 1'b0) begin
      s_mosi = {s_mosi[38:0], o_sdi};
      s_edges++;
   end
   always @(posedge o_cs) begin
      tr_mosi.push_back(s_mosi);
      tr_edges.push_back(s_edges);
      i_sdo = 1'($urandom);
   end

   // ---------------- protocol monitor ----------------
   logic chk_en = 1'b0;
   logic p_cs = 1'b1, p_spc = 1'b1, p_sdi = 1'b0, c2f_armed = 1'b0;
   int   spc_idle_err = 0, sdi_err = 0, vbr_err = 0, valid_cnt = 0;
   int   c2f_cnt = 0, c2f_err = 0, c2f_seen = 0;

   always @(negedge clk) begin
      if (chk_en) begin
         if (o_cs && !o_spc) spc_idle_err++;
         if (!p_spc && o_spc && (o_sdi !== p_sdi)) sdi_err++;
         if (o_valid && !o_ready) vbr_err++;
         if (o_valid) valid_cnt++;
         if (c2f_armed) begin
            c2f_cnt++;
            if (p_spc && !o_spc) begin
               c2f_armed = 1'b0;
               c2f_seen++;
               if (c2f_cnt != 2) c2f_err++;
            end
         end
         if (p_cs && !o_cs) begin
            c2f_armed = 1'b1;
            c2f_cnt   = 0;
         end
      end else begin
         c2f_armed = 1'b0;
      end
      p_cs  = o_cs;
      p_spc = o_spc;
      p_sdi = o_sdi;
   end

   // ---------------- driver tasks ----------------
   task automatic run_config();
      int k;
      logic prev_ready;
      k = 0;
      while (o_cs && k < 200) begin @(negedge clk); k++; end
      chk("startup_cycles", 32'(k), 32'(STARTUP));
      k = 0;
      while (!o_cs && k < 500) begin @(negedge clk); k++; end
      k = 0;
      while (o_cs && k < 200) begin @(negedge clk); k++; end
      chk("cfg_cs_gap", 32'(k), 32'(GAP));
      prev_ready = o_ready;
      k = 0;
      while (!o_cs && k < 500) begin prev_ready = o_ready; @(negedge clk); k++; end
      chk("ready_before_cs_rise", 32'(prev_ready), 32'd0);
      chk("ready_at_cs_rise", 32'(o_ready), 32'd1);
      chk("cfg_count", 32'(tr_edges.size()), 32'd2);
      if (tr_edges.size() >= 2) begin
         chk("cfg_fmt_bytes", 32'(tr_mosi[0][15:0]), 32'h3100);
         chk("cfg_fmt_edges", 32'(tr_edges[0]), 32'd16);
         chk("cfg_pwr_bytes", 32'(tr_mosi[1][15:0]), 32'h2D08);
         chk("cfg_pwr_edges", 32'(tr_edges[1]), 32'd16);
      end
   endtask

   task automatic do_read(input logic [15:0] x, input logic [15:0] y);
      int k, st;
      logic [15:0] e;
      logic [39:0] m;
      slave_x = x;
      slave_y = y;
      exp_q.push_back({model(x), Y_EN ? model(y) : 8'h00});
      k = 0;
      while (o_cs && k < 1000) begin @(negedge clk); k++; end
      chk("read_start", 32'(o_cs), 32'd0);
      st = cyc;
      if (prev_start >= 0) chk("read_spacing", 32'(st - prev_start), 32'(POLL));
      prev_start = st;
      k = 0;
      while (!o_cs && k < 1000) begin @(negedge clk); k++; end
      chk("read_end", 32'(o_cs), 32'd1);
      chk("valid_early", 32'(o_valid), 32'd0);
      @(negedge clk);
      chk("valid_pulse", 32'(o_valid), 32'd1);
      n_reads++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("av_x", 32'(o_av_x), 32'(e[15:8]));
         chk("av_y", 32'(o_av_y), 32'(e[7:0]));
      end
      @(negedge clk);
      chk("valid_single", 32'(o_valid), 32'd0);
      chk("read_edges", 32'(tr_edges[$]), 32'(RD_EDGES));
      m = tr_mosi[$];
      chk("read_cmd", 32'(8'(m >> (RD_EDGES - 8))), 32'hF2);
   endtask

   // ---------------- directed sequence ----------------
   logic [15:0] dir_x[6] = '{16'h01FF, 16'hFE00, 16'hFFFD, 16'h0003, 16'h7FFF, 16'h8000};

   initial begin
      int k;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_cs", 32'(o_cs), 32'd1);
      chk("rst_spc", 32'(o_spc), 32'd1);
      chk("rst_sdi", 32'(o_sdi), 32'd0);
      chk("rst_av_x", 32'(o_av_x), 32'd0);
      chk("rst_av_y", 32'(o_av_y), 32'd0);
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_ready", 32'(o_ready), 32'd0);
      tr_mosi.delete();
      tr_edges.delete();
      rst_n  = 1'b1;
      chk_en = 1'b1;
      run_config();

      do_read(16'h0040, 16'hFF00);
      foreach (dir_x[i]) do_read(dir_x[i], 16'($urandom));
      for (int i = 0; i < 6; i++) do_read(16'($urandom), 16'($urandom));
      do_read(16'h0100, 16'h0C00);

      // Abort a read partway through its data bytes.
      slave_x = 16'h0123;
      slave_y = 16'h4567;
      k = 0;
      while (o_cs && k < 1000) begin @(negedge clk); k++; end
      k = 0;
      while (s_edges < MID_EDGE && k < 500) begin @(negedge clk); k++; end
      chk("mid_read_reached", 32'(s_edges >= MID_EDGE), 32'd1);
      chk_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      chk("abort_cs", 32'(o_cs), 32'd1);
      chk("abort_spc", 32'(o_spc), 32'd1);
      chk("abort_av_x", 32'(o_av_x), 32'd0);
      chk("abort_av_y", 32'(o_av_y), 32'd0);
      chk("abort_ready", 32'(o_ready), 32'd0);
      tr_mosi.delete();
      tr_edges.delete();
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst_n      = 1'b1;
      chk_en     = 1'b1;
      prev_start = -1;
      run_config();
      do_read(16'h0040, 16'hFF00);
      do_read(16'($urandom), 16'($urandom));
      repeat (5) @(negedge clk);

      chk("spc_idle_high", 32'(spc_idle_err), 32'd0);
      chk("sdi_stable_at_rise", 32'(sdi_err), 32'd0);
      chk("cs_to_first_fall", 32'(c2f_err), 32'd0);
      chk("cs_fall_seen", 32'(c2f_seen > 0), 32'd1);
      chk("valid_before_ready", 32'(vbr_err), 32'd0);
      chk("valid_count", 32'(valid_cnt), 32'(n_reads));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no finish expected finish within 200000 cycles");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/adxl345_axis_reader.md
# adxl345_axis_reader

SPI master that configures an ADXL345 accelerometer and polls its X (and optionally Y) data registers at a fixed rate. It converts the 16-bit raw samples to saturated signed 8-bit values. It sits directly upstream of the paddle and wheel level handlers, which threshold its outputs into control levels. It owns the four SPI pins to the sensor.

## Interface
Parameters:
- CLK_DIV, 25: i_clk cycles per SPC half-period; 50 MHz gives a 1 MHz SPC. Minimum value 2.
- STARTUP_CYCLES, 100000: cycles after reset release before the first transaction (sensor power-up).
- POLL_CYCLES, 50000: cycles from one read start to the next read start.
- CS_GAP, 50: minimum cycles o_CS stays high between transactions.
- DATA_FORMAT, 8'h00: value written to register 0x31.
- SHIFT, 2: arithmetic right shift applied to the raw 16-bit sample before saturation.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- o_CS  out  1  sensor chip select, active low.
- o_SPC  out  1  SPI clock; CPOL=1, CPHA=1.
- o_SDI  out  1  master-to-sensor data, MSB first.
- i_SDO  in  1  sensor-to-master data.
- o_av_x  out  8  signed X acceleration.
- o_av_y  out  8  signed Y acceleration.
- o_valid  out  1  one-cycle pulse when o_av_x/o_av_y update.
- o_ready  out  1  high once configuration has completed.

## Operation
- States: WAIT_START → CFG_FMT → CFG_PWR → POLL_WAIT → READ → UPDATE → POLL_WAIT.
- WAIT_START: count STARTUP_CYCLES.
- CFG_FMT: 2-byte write of 0x31 followed by DATA_FORMAT.
- CFG_PWR: 2-byte write of 0x2D followed by 0x08 (measure mode). o_ready goes high on the cycle o_CS returns high after this write, and stays high until reset.
- READ: command byte 0xF2 (read, multi-byte, address 0x32), then burst bytes in order X0, X1, Y0, Y1. Low byte comes first: raw = {byte1, byte0}.
- UPDATE: v = raw >>> SHIFT, computed on the 16-bit signed value. Saturate to [-128, 127]. Write both axes in the same cycle and pulse o_valid in that cycle.
- POLL_WAIT: a poll counter starts counting at every READ entry. The next READ starts when both conditions hold:
  - POLL_CYCLES have elapsed since the previous READ entry.
  - o_CS has been high for at least CS_GAP cycles.
- If a transaction lasts longer than POLL_CYCLES, the next READ starts immediately after CS_GAP.
- Configuration is never repeated without a reset.
- Reset values: o_CS=1, o_SPC=1, o_SDI=0, o_av_x=0, o_av_y=0, o_valid=0, o_ready=0. All internal state returns to WAIT_START.
- Reset mid-transaction aborts it asynchronously: o_CS and o_SPC go high, and partial data is discarded.
- i_SDO is ignored while o_CS is high.

## Timing
- Transaction sequence:
  - o_CS falls.
  - CLK_DIV cycles later, o_SPC falls and o_SDI drives bit 7.
  - o_SPC rises CLK_DIV cycles after each fall; the master samples i_SDO on that rising edge.
- Each bit lasts 2·CLK_DIV cycles. o_SDI changes only on falling o_SPC, so it is stable at every rising edge.
- After the last rising edge, o_CS rises CLK_DIV cycles later; o_SPC stays high.
- During read data bytes o_SDI is held 0.
- Write transactions are 16 SPC periods; read is 40 SPC periods (24 when ADXL_Y_AXIS_EN is undefined).
- Latency: o_av_* and o_valid are registered 1 cycle after o_CS rises at the end of READ.
- Outputs hold their values between updates, so downstream consumers may sample them at any time.

## Configuration
- Macro ADXL_Y_AXIS_EN.
- Defined: burst reads 4 data bytes and o_av_y tracks the Y axis.
- Undefined: burst reads 2 data bytes (X0, X1 only), o_av_y is tied to 0, and the Y datapath is not synthesized.

## Test plan
Run all scenarios with CLK_DIV=2, STARTUP_CYCLES=20, POLL_CYCLES=400, CS_GAP=4, and an SPI slave model attached.
- Config sequence: release reset → after 20 cycles the slave sees write 0x31,0x00, then write 0x2D,0x08; o_ready rises exactly when o_CS goes high after the second write; o_valid stays 0 before that.
- Nominal read: slave returns X=0x0040 and Y=0xFF00 → command byte 0xF2, then o_av_x=16 and o_av_y=-64 with a single o_valid pulse 1 cycle after o_CS rises.
- Arithmetic and saturation:
  - X=0x01FF → 127.
  - X=0xFE00 → -128.
  - X=0xFFFD → -1 (arithmetic shift).
  - X=0x0003 → 0.
- SPI protocol and rate:
  - Checker confirms o_SPC idles high, o_SDI never changes on a rising edge, and CS-low to first falling edge is 2 cycles.
  - 40 SPC rising edges per read.
  - READ starts are spaced exactly 400 cycles apart.
- Reset mid-read: drop i_rst_n during the third data byte → o_CS=1, o_SPC=1, o_av_*=0, o_ready=0 without waiting for a clock edge. After release, the full config sequence repeats.
- Macro undefined: read has 24 SPC edges and o_av_y stays 0 while the slave drives nonzero Y bytes.
